// File: rtl/power_domain_scheduler.sv
// Serialises on/off transitions of N rail sequencers so only one domain moves at a time,
// with per-domain timeout and brown-out detection that faults and forces the domain off.
module power_domain_scheduler #(
    parameter int N_DOM   = 4,
    parameter int TIMEOUT = 32,
    parameter int GAP     = 8,
    localparam int IW     = $clog2(N_DOM),
    localparam int TMAX   = (TIMEOUT > GAP) ? TIMEOUT : GAP,
    localparam int TW     = $clog2(TMAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_DOM-1:0] req,
    input  logic [N_DOM-1:0] ready,
    input  logic             fault_clr,
    output logic [N_DOM-1:0] onoff,
    output logic [N_DOM-1:0] fault,
    output logic             busy,
    output logic [IW-1:0]    active_dom
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_UP = 2'd1,
        S_WAIT_DN = 2'd2,
        S_GAP     = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [N_DOM-1:0]  onoff_r, onoff_s;
    logic [N_DOM-1:0]  fault_r, fault_s;
    logic              busy_r, busy_s;
    logic [IW-1:0]     active_r, active_s;
    logic [IW-1:0]     rr_ptr_r, rr_ptr_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic [N_DOM-1:0]  brown_s, dn_mask_s, up_mask_s;
    logic [IW:0]       pick_s;
    logic [IW-1:0]     win_s;

    // Round-robin search of mask starting at ptr; returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [N_DOM-1:0] mask, input logic [IW-1:0] ptr);
        logic [IW:0]   res;
        logic [IW-1:0] idx_v;
        int            idx_i;
        res = '0;
        for (int k = N_DOM - 1; k >= 0; k--) begin
            idx_i = int'(ptr) + k;
            if (idx_i >= N_DOM) begin
                idx_i = idx_i - N_DOM;
            end
            idx_v = IW'(idx_i);
            if (mask[idx_v]) begin
                res = {1'b1, idx_v};
            end
        end
        return res;
    endfunction

    // Next-state, arbitration, timeout and brown-out handling.
    always_comb begin
        state_s  = state_r;
        onoff_s  = onoff_r;
        fault_s  = fault_r & ~{N_DOM{fault_clr}};
        active_s = active_r;
        rr_ptr_s = rr_ptr_r;
        timer_s  = timer_r;

        // A domain in its own transition legitimately has onoff and ready disagreeing.
        brown_s = onoff_r & ~ready;
        if ((state_r == S_WAIT_UP) || (state_r == S_WAIT_DN)) begin
            brown_s[active_r] = 1'b0;
        end else begin
            brown_s = brown_s;
        end
        fault_s = fault_s | brown_s;
        onoff_s = onoff_s & ~brown_s;

        dn_mask_s = onoff_r & ~req & ~fault_r & ~brown_s;
        up_mask_s = ~onoff_r & req & ~fault_r;
        if (|dn_mask_s) begin
            pick_s = rr_pick(dn_mask_s, rr_ptr_r);
        end else begin
            pick_s = rr_pick(up_mask_s, rr_ptr_r);
        end
        win_s = pick_s[IW-1:0];

        case (state_r)
            S_IDLE: begin
                if (pick_s[IW]) begin
                    active_s = win_s;
                    if (win_s == IW'(N_DOM - 1)) begin
                        rr_ptr_s = '0;
                    end else begin
                        rr_ptr_s = win_s + IW'(1);
                    end
                    onoff_s[win_s] = ~onoff_r[win_s];
                    timer_s        = '0;
                    state_s        = onoff_r[win_s] ? S_WAIT_DN : S_WAIT_UP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT_UP: begin
                if (ready[active_r]) begin
                    state_s = S_GAP;
                    timer_s = '0;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    fault_s[active_r] = 1'b1;
                    onoff_s[active_r] = 1'b0;
                    state_s           = S_GAP;
                    timer_s           = '0;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_WAIT_DN: begin
                if (!ready[active_r]) begin
                    state_s = S_GAP;
                    timer_s = '0;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    fault_s[active_r] = 1'b1;
                    state_s           = S_GAP;
                    timer_s           = '0;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_r == TW'(GAP - 1)) begin
                    state_s = S_IDLE;
                    timer_s = '0;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                timer_s = '0;
            end
        endcase

        busy_s = (state_s != S_IDLE);
    end

    // State and output registers; async reset drops every onoff immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            onoff_r  <= '0;
            fault_r  <= '0;
            busy_r   <= 1'b0;
            active_r <= '0;
            rr_ptr_r <= '0;
            timer_r  <= '0;
        end else begin
            state_r  <= state_s;
            onoff_r  <= onoff_s;
            fault_r  <= fault_s;
            busy_r   <= busy_s;
            active_r <= active_s;
            rr_ptr_r <= rr_ptr_s;
            timer_r  <= timer_s;
        end
    end

    assign onoff      = onoff_r;
    assign fault      = fault_r;
    assign busy       = busy_r;
    assign active_dom = active_r;

endmodule

// File: tb/tb_power_domain_scheduler.sv
// Directed bench for power_domain_scheduler: a behavioural sequencer model answers onoff
// with ready after SEQ_DLY cycles; vectors and corner sequences are hand-computed.
module tb_power_domain_scheduler;

    localparam int TIMEOUT = 32;
    localparam int GAP     = 8;
    localparam int SEQ_DLY = 12;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fault_clr;
    logic [3:0] req, ready, onoff, fault;
    logic       busy;
    logic [1:0] active_dom;

    always #5 clk = ~clk;

    power_domain_scheduler #(.N_DOM(4), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .ready(ready), .fault_clr(fault_clr),
        .onoff(onoff), .fault(fault), .busy(busy), .active_dom(active_dom)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] ready_m, stuck, onoff_prev;
    int         cnt [4];
    int         log_dom [64];
    logic       log_val [64];
    int         log_cyc [64];
    int         log_n = 0;
    bit         chk_ovl = 1'b0;
    int         ovl_err = 0;

    typedef struct {
        logic [3:0] req;
        logic [1:0] first;
        logic [3:0] final_onoff;
    } vec_t;
    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample at negedge, log onoff edges, then advance the sequencer model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (onoff[i] !== onoff_prev[i] && log_n < 64) begin
                log_dom[log_n] = i;
                log_val[log_n] = onoff[i];
                log_cyc[log_n] = cyc;
                log_n++;
            end
        end
        onoff_prev = onoff;
        if (chk_ovl && $countones(onoff ^ ready_m) > 1) ovl_err++;
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                ready_m[i] = 1'b0;
                cnt[i] = 0;
            end else if (onoff[i] != ready_m[i]) begin
                if (cnt[i] == SEQ_DLY - 1) begin
                    ready_m[i] = onoff[i];
                    cnt[i] = 0;
                end else begin
                    cnt[i]++;
                end
            end else begin
                cnt[i] = 0;
            end
        end
        ready = ready_m & ~stuck;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 4'b0000;
        fault_clr = 1'b0;
        stuck = 4'b0000;
        ready_m = 4'b0000;
        ready = 4'b0000;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        onoff_prev = 4'b0000;
    endtask

    // Wait until busy has been low for two consecutive cycles (no pending grant).
    task automatic wait_idle(input string name);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 2 && n < 600) begin
            tick();
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        check({name, "_settle"}, 32'(quiet >= 2), 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{req: 4'b0001, first: 2'd0, final_onoff: 4'b0001};
        vecs[1] = '{req: 4'b0110, first: 2'd0, final_onoff: 4'b0110};
        vecs[2] = '{req: 4'b1001, first: 2'd1, final_onoff: 4'b1001};
        vecs[3] = '{req: 4'b1111, first: 2'd1, final_onoff: 4'b1111};
        vecs[4] = '{req: 4'b0000, first: 2'd3, final_onoff: 4'b0000};

        // Reset state and single up-transition.
        do_reset();
        check("rst_onoff", 32'(onoff), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_active", 32'(active_dom), 32'h0);
        req = 4'b0001;
        tick();
        check("t1_onoff", 32'(onoff), 32'h1);
        check("t1_active", 32'(active_dom), 32'h0);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check("t1_busy_cycles", 32'(n), 32'(SEQ_DLY + GAP));
        check("t1_fault", 32'(fault), 32'h0);

        // Arbitration table: down priority and round-robin pointer carried across rows.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            req = vecs[v].req;
            tick();
            check($sformatf("vec%0d_first", v), 32'(active_dom), 32'(vecs[v].first));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'h1);
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_onoff", v), 32'(onoff), 32'(vecs[v].final_onoff));
        end

        // All domains requested at once: serial, ordered, spaced by SEQ_DLY+GAP+1.
        do_reset();
        log_n = 0;
        ovl_err = 0;
        chk_ovl = 1'b1;
        req = 4'b1111;
        wait_idle("t2");
        chk_ovl = 1'b0;
        check("t2_edges", 32'(log_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_dom%0d", k), 32'(log_dom[k]), 32'(k));
            check($sformatf("t2_val%0d", k), 32'(log_val[k]), 32'h1);
        end
        for (int k = 1; k < 4; k++)
            check($sformatf("t2_space%0d", k), 32'(log_cyc[k] - log_cyc[k-1]), 32'(SEQ_DLY + GAP + 1));
        check("t2_overlap", 32'(ovl_err), 32'd0);

        // Down priority with re-request of the domain going down.
        log_n = 0;
        req = 4'b0110;
        tick();
        repeat (4) tick();
        req = 4'b0111;
        wait_idle("t3");
        check("t3_edges", 32'(log_n), 32'd3);
        check("t3_e0", {log_dom[0][30:0], log_val[0]}, {31'd0, 1'b0});
        check("t3_e1", {log_dom[1][30:0], log_val[1]}, {31'd3, 1'b0});
        check("t3_e2", {log_dom[2][30:0], log_val[2]}, {31'd0, 1'b1});
        check("t3_onoff", 32'(onoff), 32'h7);

        // Power-up timeout, exclusion while faulted, and fault_clr re-grant.
        do_reset();
        stuck = 4'b0100;
        req = 4'b0100;
        tick();
        check("t4_grant", 32'(onoff), 32'h4);
        n = 0;
        while (!fault[2] && n < 100) begin
            tick();
            n++;
        end
        check("t4_timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("t4_onoff_off", 32'(onoff), 32'h0);
        repeat (40) tick();
        check("t4_ignored_busy", 32'(busy), 32'h0);
        check("t4_ignored_onoff", 32'(onoff), 32'h0);
        check("t4_fault_held", 32'(fault), 32'h4);
        stuck = 4'b0000;
        ready = ready_m & ~stuck;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("t4_clr_fault", 32'(fault), 32'h0);
        check("t4_clr_onoff", 32'(onoff), 32'h0);
        tick();
        check("t4_regrant", 32'(onoff), 32'h4);
        check("t4_regrant_dom", 32'(active_dom), 32'h2);

        // Brown-out on a settled domain during another domain's transition.
        do_reset();
        req = 4'b0010;
        wait_idle("t5a");
        req = 4'b1010;
        tick();
        repeat (3) tick();
        stuck = 4'b0010;
        ready = ready_m & ~stuck;
        tick();
        check("t5_fault", 32'(fault), 32'h2);
        check("t5_onoff", 32'(onoff), 32'h8);
        check("t5_busy", 32'(busy), 32'h1);
        check("t5_active", 32'(active_dom), 32'h3);
        wait_idle("t5b");
        check("t5_final_onoff", 32'(onoff), 32'h8);
        check("t5_final_fault", 32'(fault), 32'h2);

        // Asynchronous reset in the middle of a WAIT_UP.
        do_reset();
        stuck = 4'b0110;
        ready = ready_m & ~stuck;
        req = 4'b0010;
        wait_idle("t6a");
        check("t6_prefault", 32'(fault), 32'h2);
        req = 4'b0110;
        tick();
        repeat (10) tick();
        check("t6_midwait", {30'd0, busy, onoff[2]}, 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_onoff", 32'(onoff), 32'h0);
        check("t6_async_fault", 32'(fault), 32'h0);
        check("t6_async_busy", 32'(busy), 32'h0);
        check("t6_async_active", 32'(active_dom), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
